ad9226_dac_tx: RTL

//   Transmit side of the parallel-bus converter interface: takes samples from a ready/valid stream and drives a

---
 rtl/ad9226_dac_pkg.sv | 13 +
 rtl/ad9226_dac_tx_fifo.sv | 56 +++++
 rtl/ad9226_dac_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ad9226_dac_pkg.sv
// Shared types and defaults for the AD9226-style parallel DAC transmit path.
package ad9226_dac_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned DEFAULT_CLK_DIV   = 4;
  localparam int unsigned HALF              = DEFAULT_CLK_DIV / 2;
  localparam logic [11:0] DEFAULT_IDLE_CODE = 12'h800;

endpackage

// File: rtl/ad9226_dac_tx_fifo.sv
// First-word-fall-through sample FIFO: head is valid whenever empty is low.
// No bypass path, so a word written at one edge is poppable from the next.
module sync_fifo_fwft
  import ad9226_dac_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ad9226_dac_tx.sv
// Streams FIFO'd samples onto a parallel DAC bus with a divided, registered
// sample clock; data is launched on the dac_clk falling edge.
module ad9226_dac_tx
  import ad9226_dac_pkg::*;
#(
  parameter int unsigned                DAC_DATA_WIDTH = 12,
  parameter int unsigned                CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int unsigned                FIFO_DEPTH     = 4,
  parameter logic [DAC_DATA_WIDTH-1:0]  IDLE_CODE      = DAC_DATA_WIDTH'(DEFAULT_IDLE_CODE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [DAC_DATA_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      dac_clk,
  output logic [DAC_DATA_WIDTH-1:0] dac_data,
  output logic                      busy,
  output logic                      underrun,
  output logic                      underrun_flag,
  input  logic                      clr_underrun
);

  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

  state_t                    state, state_n;
  logic [CW-1:0]             div_cnt, div_n, div_inc;
  logic                      dac_clk_n;
  logic [DAC_DATA_WIDTH-1:0] dac_data_n;
  logic                      busy_n;
  logic                      underrun_n;
  logic                      flag_n;
  logic                      ready_q;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DAC_DATA_WIDTH-1:0] fifo_head;

  // ready_q keeps s_ready low through reset and for the release edge itself
  assign s_ready = ready_q && !fifo_full;

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DAC_DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign div_inc = (div_cnt == LAST_CNT) ? '0 : div_cnt + 1'b1;

  always_comb begin
    state_n    = state;
    div_n      = div_cnt;
    dac_clk_n  = dac_clk;
    dac_data_n = dac_data;
    busy_n     = busy;
    underrun_n = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        div_n      = '0;
        dac_clk_n  = 1'b0;
        dac_data_n = IDLE_CODE;
        busy_n     = 1'b0;
        if (enable && !fifo_empty) begin
          state_n    = RUN;
          dac_data_n = fifo_head;
          fifo_pop   = 1'b1;
          div_n      = HALF_CNT;
          busy_n     = 1'b1;
        end
      end
      RUN: begin
        div_n     = div_inc;
        dac_clk_n = (div_inc < HALF_CNT);
        // launch point: dac_clk falls here, so stopping never truncates a high phase
        if (div_inc == HALF_CNT) begin
          if (!enable) begin
            state_n    = IDLE;
            dac_data_n = IDLE_CODE;
            dac_clk_n  = 1'b0;
            div_n      = '0;
            busy_n     = 1'b0;
          end else if (!fifo_empty) begin
            dac_data_n = fifo_head;
            fifo_pop   = 1'b1;
          end else begin
            underrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign flag_n = underrun_n ? 1'b1 : (clr_underrun ? 1'b0 : underrun_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      dac_clk       <= 1'b0;
      dac_data      <= IDLE_CODE;
      busy          <= 1'b0;
      underrun      <= 1'b0;
      underrun_flag <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state         <= state_n;
      div_cnt       <= div_n;
      dac_clk       <= dac_clk_n;
      dac_data      <= dac_data_n;
      busy          <= busy_n;
      underrun      <= underrun_n;
      underrun_flag <= flag_n;
      ready_q       <= 1'b1;
    end
  end

endmodule
